// File: rtl/sliding_extremum_filter_pkg.sv
// Shared definitions for the sliding extremum filter: mode encoding,
// comparator helper and window-length helper.
package sliding_filter_pkg;

    // Internal width used by the comparator helper; callers sign-extend into it.
    localparam int SEL_W = 32;

    localparam logic MODE_MAX = 1'b0;
    localparam logic MODE_MIN = 1'b1;

    // Window length from its log2.
    function automatic int win_of(input int log2);
        return 32'sd1 << log2;
    endfunction

    // Signed maximum (MODE_MAX) or minimum (MODE_MIN) of two operands.
    // Ties return the same value either way, so operand order does not matter.
    function automatic logic signed [SEL_W-1:0] sel_extremum(
        input logic signed [SEL_W-1:0] a,
        input logic signed [SEL_W-1:0] b,
        input logic                    mode
    );
        logic signed [SEL_W-1:0] res;
        if (mode == MODE_MAX) begin
            res = (a >= b) ? a : b;
        end else begin
            res = (a <= b) ? a : b;
        end
        return res;
    endfunction

endpackage

// File: rtl/sliding_extremum_filter_if.sv
// Sample-in / extremum-out bus of the sliding extremum filter.
// With PEAK_TO_PEAK_EN defined the bus also carries out_pp.
interface sliding_extremum_filter_if #(
    parameter int DATA_W = 12
);
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     mode;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_data;
    logic                     primed;
`ifdef PEAK_TO_PEAK_EN
    logic        [DATA_W:0]   out_pp;

    modport master (output in_valid, in_data, mode,
                    input  out_valid, out_data, primed, out_pp);
    modport slave  (input  in_valid, in_data, mode,
                    output out_valid, out_data, primed, out_pp);
`else
    modport master (output in_valid, in_data, mode,
                    input  out_valid, out_data, primed);
    modport slave  (input  in_valid, in_data, mode,
                    output out_valid, out_data, primed);
`endif
endinterface

// File: rtl/sliding_extremum_filter_tree_level.sv
// One registered level of the compare tree. Each node reduces a pair of
// operands; TREES parallel trees share the valid/mode tags, tree t>0
// comparing in the opposite direction to the carried mode.
module extremum_tree_level
    import sliding_filter_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int NODES  = 1,
    parameter int TREES  = 1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [2*NODES-1:0][TREES-1:0][DATA_W-1:0] data_i,
    input  logic                                      valid_i,
    input  logic                                      mode_i,
    output logic [NODES-1:0][TREES-1:0][DATA_W-1:0]   data_q,
    output logic                                      valid_q,
    output logic                                      mode_q
);

    logic [NODES-1:0][TREES-1:0][DATA_W-1:0] data_d;

    // Pairwise signed compare of children 2j and 2j+1 into node j.
    always_comb begin
        data_d = '0;
        for (int j = 0; j < NODES; j++) begin
            for (int t = 0; t < TREES; t++) begin
                data_d[j][t] = DATA_W'(sel_extremum(
                    SEL_W'($signed(data_i[2*j][t])),
                    SEL_W'($signed(data_i[2*j+1][t])),
                    mode_i ^ (t != 0)));
            end
        end
    end

    // Level register; advances every clock, tags travel with the data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_i;
            mode_q  <= mode_i;
        end
    end

endmodule

// File: rtl/sliding_extremum_filter.sv
// Sliding-window max/min peak detector over the last 2**WIN_LOG2 accepted
// signed samples. Optional PEAK_TO_PEAK_EN adds a second, opposite-direction
// tree and a registered out_pp = max - min.
// The tree is stored heap-style: node i has children 2i and 2i+1, the
// window occupies indices WIN..2*WIN-1 and the root is index 1.
module sliding_extremum_filter
    import sliding_filter_pkg::*;
#(
    parameter int DATA_W   = 12,
    parameter int WIN_LOG2 = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    sliding_extremum_filter_if.slave bus
);

    localparam int WIN = win_of(WIN_LOG2);
`ifdef PEAK_TO_PEAK_EN
    localparam int TREES = 2;
`else
    localparam int TREES = 1;
`endif
    localparam logic [WIN_LOG2:0] CNT_FULL = (WIN_LOG2+1)'(WIN);
    localparam logic [WIN_LOG2:0] CNT_LAST = (WIN_LOG2+1)'(WIN - 1);

    logic [WIN-1:0][DATA_W-1:0]              win_q, win_d;
    logic [WIN_LOG2:0]                       cnt_q, cnt_d;
    logic                                    primed_q, primed_d;
    logic                                    vld_q, vld_d;
    logic                                    mode_q, mode_d;
    logic [2*WIN-1:1][TREES-1:0][DATA_W-1:0] heap_s;
    logic [WIN_LOG2:0]                       vld_s;
    logic [WIN_LOG2:0]                       mode_s;
    logic                                    out_valid_q, out_valid_d;
    logic [DATA_W-1:0]                       out_data_q, out_data_d;

    // Window shift, priming count and entry tags for an accepted sample.
    always_comb begin
        win_d    = win_q;
        cnt_d    = cnt_q;
        vld_d    = 1'b0;
        mode_d   = mode_q;
        if (bus.in_valid) begin
            win_d  = {win_q[WIN-2:0], bus.in_data};
            mode_d = bus.mode;
            vld_d  = (cnt_q == CNT_LAST) || primed_q;
            if (cnt_q != CNT_FULL) begin
                cnt_d = cnt_q + (WIN_LOG2+1)'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            win_d = win_q;
            cnt_d = cnt_q;
        end
        primed_d = (cnt_d == CNT_FULL);
    end

    // Window and priming state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q    <= '0;
            cnt_q    <= '0;
            primed_q <= 1'b0;
            vld_q    <= 1'b0;
            mode_q   <= 1'b0;
        end else begin
            win_q    <= win_d;
            cnt_q    <= cnt_d;
            primed_q <= primed_d;
            vld_q    <= vld_d;
            mode_q   <= mode_d;
        end
    end

    assign vld_s[0]  = vld_q;
    assign mode_s[0] = mode_q;

    for (genvar i = 0; i < WIN; i++) begin : g_leaf
        for (genvar t = 0; t < TREES; t++) begin : g_tree
            assign heap_s[WIN+i][t] = win_q[i];
        end
    end

    for (genvar l = 1; l <= WIN_LOG2; l++) begin : g_lvl
        localparam int N = WIN >> l;
        extremum_tree_level #(
            .DATA_W (DATA_W),
            .NODES  (N),
            .TREES  (TREES)
        ) u_level (
            .clk     (clk),
            .rst     (rst),
            .data_i  (heap_s[4*N-1:2*N]),
            .valid_i (vld_s[l-1]),
            .mode_i  (mode_s[l-1]),
            .data_q  (heap_s[2*N-1:N]),
            .valid_q (vld_s[l]),
            .mode_q  (mode_s[l])
        );
    end

    // Output stage: capture the root on a valid result, hold otherwise.
    always_comb begin
        out_valid_d = vld_s[WIN_LOG2];
        if (vld_s[WIN_LOG2]) begin
            out_data_d = heap_s[1][0];
        end else begin
            out_data_d = out_data_q;
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.primed    = primed_q;

`ifdef PEAK_TO_PEAK_EN
    logic [DATA_W:0]        out_pp_q, out_pp_d;
    logic signed [DATA_W:0] ext_sel_s, ext_opp_s;

    // Tree 0 follows mode and tree 1 is opposite, so max - min depends on mode.
    always_comb begin
        ext_sel_s = (DATA_W+1)'($signed(heap_s[1][0]));
        ext_opp_s = (DATA_W+1)'($signed(heap_s[1][1]));
        if (!vld_s[WIN_LOG2]) begin
            out_pp_d = out_pp_q;
        end else if (mode_s[WIN_LOG2] == MODE_MAX) begin
            out_pp_d = ext_sel_s - ext_opp_s;
        end else begin
            out_pp_d = ext_opp_s - ext_sel_s;
        end
    end

    // Peak-to-peak register, same latency and qualifier as out_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_pp_q <= '0;
        end else begin
            out_pp_q <= out_pp_d;
        end
    end

    assign bus.out_pp = out_pp_q;
`else
    // The mode tag at the root is only consumed by the peak-to-peak stage.
    logic unused_root_mode_s;
    assign unused_root_mode_s = mode_s[WIN_LOG2];
`endif

endmodule

// File: tb/tb_sliding_extremum_filter.sv
// Scoreboard bench for sliding_extremum_filter (WIN_LOG2=4, DATA_W=12).
// With PEAK_TO_PEAK_EN defined a second WIN_LOG2=2 instance checks out_pp.
module tb_sliding_extremum_filter;

    localparam int DATA_W   = 12;
    localparam int WIN_LOG2 = 4;
    localparam int WIN      = 16;
    localparam int LAT      = WIN_LOG2 + 1;

    typedef struct {
        int data;
        int acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sliding_extremum_filter_if #(.DATA_W(DATA_W)) sif ();

    sliding_extremum_filter #(
        .DATA_W   (DATA_W),
        .WIN_LOG2 (WIN_LOG2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;
    int   last_out = 0;
    int   mdl_win[$];
    int   mdl_acc = 0;
    exp_t exp_q[$];

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Posedge counter used to measure result latency.
    always @(posedge clk) cyc++;

    // Drive one cycle of stimulus and update the reference window model.
    task automatic drive(input logic v, input int d, input logic m);
        exp_t e;
        int   ext;
        @(negedge clk);
        chk("primed", int'(sif.primed), int'(mdl_acc >= WIN));
        sif.in_valid = v;
        sif.in_data  = DATA_W'(d);
        sif.mode     = m;
        if (v) begin
            mdl_win.push_front(d);
            if (mdl_win.size() > WIN) void'(mdl_win.pop_back());
            mdl_acc++;
            if (mdl_acc >= WIN) begin
                ext = mdl_win[0];
                foreach (mdl_win[i]) begin
                    if (!m && mdl_win[i] > ext) ext = mdl_win[i];
                    if (m && mdl_win[i] < ext) ext = mdl_win[i];
                end
                e.data    = ext;
                e.acc_cyc = cyc + 1;
                exp_q.push_back(e);
            end
        end
    endtask

    // Pulse reset between clock edges and clear the model.
    task automatic pulse_reset();
        @(negedge clk);
        #2;
        rst          = 1'b1;
        sif.in_valid = 1'b0;
        exp_q.delete();
        mdl_win.delete();
        mdl_acc  = 0;
        last_out = 0;
        #1;
        chk("rst_out_valid", int'(sif.out_valid), 0);
        chk("rst_out_data", int'($signed(sif.out_data)), 0);
        chk("rst_primed", int'(sif.primed), 0);
        @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Scoreboard monitor: every result must match the model and its latency.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (sif.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", int'($signed(sif.out_data)), e.data);
                    chk("latency", cyc - e.acc_cyc, LAT);
                    last_out = e.data;
                end
            end else begin
                chk("hold", int'($signed(sif.out_data)), last_out);
            end
        end
    end

`ifdef PEAK_TO_PEAK_EN
    sliding_extremum_filter_if #(.DATA_W(DATA_W)) sif2 ();

    sliding_extremum_filter #(
        .DATA_W   (DATA_W),
        .WIN_LOG2 (2)
    ) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (sif2)
    );

    int p2p_vals[4] = '{2047, -2048, 0, 5};
`endif

    initial begin
        rst          = 1'b1;
        sif.in_valid = 1'b0;
        sif.in_data  = '0;
        sif.mode     = 1'b0;
`ifdef PEAK_TO_PEAK_EN
        sif2.in_valid = 1'b0;
        sif2.in_data  = '0;
        sif2.mode     = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("init_out_valid", int'(sif.out_valid), 0);
        chk("init_out_data", int'($signed(sif.out_data)), 0);
        chk("init_primed", int'(sif.primed), 0);
        #2;
        rst = 1'b0;

        // Priming with 1..16, then a sliding max of -2048.
        for (int i = 1; i <= WIN; i++) drive(1'b1, i, 1'b0);
        for (int i = 0; i < WIN; i++) drive(1'b1, -2048, 1'b0);

        // Alternating window, then switch to minimum mid-stream.
        for (int i = 0; i < WIN; i++) drive(1'b1, (i % 2 == 0) ? -300 : 100, 1'b0);
        drive(1'b1, -300, 1'b1);
        drive(1'b1, 100, 1'b1);
        drive(1'b1, 100, 1'b1);
        drive(1'b1, -300, 1'b0);

        // Gapped valid: one accepted sample in four cycles.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, int'($urandom_range(0, 4095)) - 2048, 1'(i % 3 == 0));
            repeat (3) drive(1'b0, 0, 1'b0);
        end

        // Reset while results are in flight, then re-prime from scratch.
        for (int i = 0; i < 3; i++) drive(1'b1, 500 + i, 1'b0);
        pulse_reset();
        for (int i = 0; i < WIN + 4; i++) drive(1'b1, 40 - i, 1'b0);

        repeat (LAT + 3) drive(1'b0, 0, 1'b0);
        chk("drain_empty", exp_q.size(), 0);

`ifdef PEAK_TO_PEAK_EN
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            sif2.in_valid = 1'b1;
            sif2.in_data  = DATA_W'(p2p_vals[k]);
        end
        @(negedge clk);
        sif2.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("p2p_early_valid", int'(sif2.out_valid), 0);
        @(negedge clk);
        chk("p2p_out_valid", int'(sif2.out_valid), 1);
        chk("p2p_out_data", int'($signed(sif2.out_data)), 2047);
        chk("p2p_out_pp", int'(sif2.out_pp), 4095);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
